mmio_resume_ctrl: RTL

Service-side counterpart of the break generator that halts the emulated core (encore) on MMIO writes. On each core MMIO write it captures address, data and strobes; once the generator raises its MMIO break it offers the record to the host over a valid/ready handshake, waits for host completion (or a timeout), and then pulses `turn2run` so the generator releases the break. It also keeps a saturating count of cycles the core spent stalled on MMIO.

---
 rtl/mmio_resume_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mmio_resume_ctrl.sv
// mmio_resume_ctrl
// Service side of the MMIO break mechanism. A core MMIO write is captured
// into a record. Once the break generator raises irq_mmio, the record is
// offered to the host over a valid/ready handshake. The block then waits for
// host_done, or for a timeout, and pulses turn2run so the break is released.
// It also counts the cycles spent away from IDLE, saturating at the maximum.
//
// Ports:
//   clk, reset               clock and synchronous active-high reset
//   wenable, isMMIO          core write strobe / MMIO target qualifier
//   mmio_addr/wdata/wstrb    core write record
//   irq_mmio                 break asserted by the break generator
//   req_valid, req_ready     host handshake for the captured record
//   req_addr/wdata/wstrb     captured record presented to the host
//   host_done                host finished servicing (one-cycle pulse)
//   turn2run                 one-cycle resume pulse to the break generator
//   timeout_err              sticky flag, set when a resume is forced
//   stall_cycles             saturating count of non-IDLE cycles
//   debug_state              current FSM state encoding
module mmio_resume_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wenable,
    input  logic                  isMMIO,
    input  logic [ADDR_W-1:0]     mmio_addr,
    input  logic [DATA_W-1:0]     mmio_wdata,
    input  logic [DATA_W/8-1:0]   mmio_wstrb,
    input  logic                  irq_mmio,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [DATA_W-1:0]     req_wdata,
    output logic [DATA_W/8-1:0]   req_wstrb,
    input  logic                  host_done,
    output logic                  turn2run,
    output logic                  timeout_err,
    output logic [31:0]           stall_cycles,
    output logic [2:0]            debug_state
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The counter starts at 0 on the first WAIT_DONE cycle and is bumped each
    // cycle without host_done; the cycle whose bump would make it TIMEOUT-1
    // is the last WAIT_DONE cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        OFFER     = 3'd2,
        WAIT_DONE = 3'd3,
        RESUME    = 3'd4,
        DRAIN     = 3'd5
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     timeout_cnt_reg;
    logic                 timeout_err_reg;
    logic [31:0]          stall_cycles_reg;
    logic [ADDR_W-1:0]    addr_reg;
    logic [DATA_W-1:0]    wdata_reg;
    logic [DATA_W/8-1:0]  wstrb_reg;

    logic capture;
    logic timeout_hit;

    assign capture     = (state_reg == IDLE) && isMMIO && wenable;
    assign timeout_hit = (state_reg == WAIT_DONE) && !host_done &&
                         (timeout_cnt_reg == CNT_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:      if (capture)   state_next = ARMED;
            ARMED:     if (irq_mmio)  state_next = OFFER;
            OFFER:     if (req_ready) state_next = WAIT_DONE;
            WAIT_DONE: begin
                // host_done takes priority over a coincident timeout
                if (host_done || timeout_hit) state_next = RESUME;
            end
            RESUME:    state_next = DRAIN;
            DRAIN:     if (!irq_mmio) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Captured record, loaded only from IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            wstrb_reg <= '0;
        end else if (capture) begin
            addr_reg  <= mmio_addr;
            wdata_reg <= mmio_wdata;
            wstrb_reg <= mmio_wstrb;
        end
    end

    // Timeout counter and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt_reg <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_reg == OFFER) begin
                timeout_cnt_reg <= '0;
            end else if (state_reg == WAIT_DONE && !host_done) begin
                timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err_reg <= 1'b1;
            end
        end
    end

    // Saturating stall counter
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles_reg <= '0;
        end else if (state_reg != IDLE && stall_cycles_reg != 32'hFFFF_FFFF) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
        end
    end

    assign req_valid    = (state_reg == OFFER);
    assign turn2run     = (state_reg == RESUME);
    assign req_addr     = addr_reg;
    assign req_wdata    = wdata_reg;
    assign req_wstrb    = wstrb_reg;
    assign timeout_err  = timeout_err_reg;
    assign stall_cycles = stall_cycles_reg;
    assign debug_state  = state_reg;

endmodule
